// File: rtl/irq_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : irq_sched_pkg
// Brief    : Shared sizes, ID encodings and FSM state type for the scheduler.
// Revision : 1.0
// ============================================================================
package irq_sched_pkg;

    localparam int NCH   = 9;
    localparam int NBUS  = 3;
    localparam int N_IRQ = NCH * NBUS;
    localparam int ID_W  = 5;

    localparam logic [ID_W-1:0] ID_NONE = 5'd31;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ASSERT  = 2'd1,
        SERVICE = 2'd2
    } state_t;

endpackage : irq_sched_pkg
`default_nettype wire

// File: rtl/irq_sched_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : irq_sched_ctrl_if
// Brief    : Request, mask and host handshake bundle of the interrupt scheduler.
// Revision : 1.0
// ============================================================================
interface irq_sched_ctrl_if
    import irq_sched_pkg::*;
;
    logic [N_IRQ-1:0] req_i;
    logic             mask_we_i;
    logic [N_IRQ-1:0] mask_d_i;
    logic             irq_ack_i;
    logic             eoi_i;
    logic             irq_o;
    logic [ID_W-1:0]  irq_id_o;
    logic             busy_o;
    logic [N_IRQ-1:0] pending_o;

    modport master (
        output req_i, mask_we_i, mask_d_i, irq_ack_i, eoi_i,
        input  irq_o, irq_id_o, busy_o, pending_o
    );

    modport slave (
        input  req_i, mask_we_i, mask_d_i, irq_ack_i, eoi_i,
        output irq_o, irq_id_o, busy_o, pending_o
    );

endinterface : irq_sched_ctrl_if
`default_nettype wire

// File: rtl/irq_sched_ctrl_prio_enc.sv
`default_nettype none
// ============================================================================
// Module   : irq_prio_enc
// Brief    : Combinational lowest-index-wins encoder over all channels.
// Revision : 1.0
// ============================================================================
module irq_prio_enc
    import irq_sched_pkg::*;
(
    input  logic [N_IRQ-1:0] req_i,
    output logic             valid_o,
    output logic [ID_W-1:0]  id_o
);

    always_comb begin
        valid_o = |req_i;
        id_o    = ID_NONE;
        // Descending scan so the lowest set index is the last assignment.
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                id_o = ID_W'(i);
            end
        end
    end

endmodule : irq_prio_enc
`default_nettype wire

// File: rtl/irq_sched_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : irq_sched_ctrl
// Brief    : Edge-latched, maskable 27-channel interrupt scheduler with
//            ack / end-of-interrupt host handshake.
// Revision : 1.0
// ============================================================================
module irq_sched_ctrl
    import irq_sched_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    irq_sched_ctrl_if.slave bus
);

    localparam logic [N_IRQ-1:0] ONE_HOT0 = {{(N_IRQ-1){1'b0}}, 1'b1};

    logic [N_IRQ-1:0] req_q,     req_d;
    logic [N_IRQ-1:0] pending_q, pending_d;
    logic [N_IRQ-1:0] mask_q,    mask_d;
    logic [ID_W-1:0]  id_q,      id_d;
    state_t           state_q,   state_d;

    logic [N_IRQ-1:0] elig;
    logic             win_valid;
    logic [ID_W-1:0]  win_id;
    logic             ack_clr;
    logic [N_IRQ-1:0] clr_vec;

    assign elig = pending_q & ~mask_q;

    irq_prio_enc u_prio_enc (
        .req_i   (elig),
        .valid_o (win_valid),
        .id_o    (win_id)
    );

    // State register and datapath flops
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            req_q     <= '0;
            pending_q <= '0;
            mask_q    <= '1;
            id_q      <= ID_NONE;
            state_q   <= IDLE;
        end else begin
            req_q     <= req_d;
            pending_q <= pending_d;
            mask_q    <= mask_d;
            id_q      <= id_d;
            state_q   <= state_d;
        end
    end

    // Next-state logic; the ack takes priority over a spurious withdraw.
    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        ack_clr = 1'b0;
        case (state_q)
            IDLE: begin
                if (win_valid) begin
                    state_d = ASSERT;
                    id_d    = win_id;
                end
            end
            ASSERT: begin
                if (bus.irq_ack_i) begin
                    state_d = SERVICE;
                    ack_clr = 1'b1;
                end else if (mask_q[id_q] || !pending_q[id_q]) begin
                    state_d = IDLE;
                end
            end
            SERVICE: begin
                if (bus.eoi_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A fresh edge on the acked channel re-sets the bit in the same cycle.
    always_comb begin
        req_d     = bus.req_i;
        mask_d    = bus.mask_we_i ? bus.mask_d_i : mask_q;
        clr_vec   = ack_clr ? (ONE_HOT0 << id_q) : '0;
        pending_d = (pending_q & ~clr_vec) | (bus.req_i & ~req_q);
    end

    // Output decode
    always_comb begin
        bus.irq_o     = (state_q == ASSERT);
        bus.busy_o    = (state_q != IDLE);
        bus.irq_id_o  = (state_q == IDLE) ? ID_NONE : id_q;
        bus.pending_o = pending_q;
    end

endmodule : irq_sched_ctrl
`default_nettype wire

// File: tb/tb_irq_sched_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_irq_sched_ctrl
// Brief    : Scoreboard bench: directed scenarios plus random traffic against
//            a behavioural scheduler model.
// Revision : 1.0
// ============================================================================
module tb_irq_sched_ctrl;

    typedef struct packed {
        logic        irq;
        logic [4:0]  id;
        logic        busy;
        logic [26:0] pend;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;
    exp_t exp_q[$];

    irq_sched_ctrl_if bus ();

    irq_sched_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Model state: phase 0 = nothing presented, 1 = offered to host, 2 = host servicing
    logic [26:0] m_req, m_pend, m_mask;
    int          m_phase, m_cur;

    function automatic int lowest(input logic [26:0] v);
        logic [26:0] lsb;
        lsb = v & (~v + 27'd1);
        for (int i = 0; i < 27; i++) if (lsb[i]) return i;
        return 31;
    endfunction

    task automatic model_step(input logic [26:0] req, input logic we, input logic [26:0] md,
                              input logic ack, input logic eoi, input logic rn);
        logic [26:0] nxt;
        if (!rn) begin
            m_req = '0; m_pend = '0; m_mask = '1; m_phase = 0; m_cur = 31;
            return;
        end
        nxt = m_pend;
        if (m_phase == 0) begin
            if ((m_pend & ~m_mask) != 0) begin
                m_cur   = lowest(m_pend & ~m_mask);
                m_phase = 1;
            end
        end else if (m_phase == 1) begin
            if (ack) begin
                nxt[m_cur] = 1'b0;
                m_phase    = 2;
            end else if (m_mask[m_cur] || !m_pend[m_cur]) begin
                m_phase = 0;
            end
        end else if (eoi) begin
            m_phase = 0;
        end
        m_pend = nxt | (req & ~m_req);
        if (we) m_mask = md;
        m_req = req;
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.irq  = (m_phase == 1);
        e.busy = (m_phase != 0);
        e.id   = (m_phase == 0) ? 5'd31 : 5'(m_cur);
        e.pend = m_pend;
        return e;
    endfunction

    // One clock of stimulus; expectation for this cycle's outputs is queued first.
    task automatic cyc(input logic [26:0] req, input logic we, input logic [26:0] md,
                       input logic ack, input logic eoi, input logic rn);
        bus.req_i     = req;
        bus.mask_we_i = we;
        bus.mask_d_i  = md;
        bus.irq_ack_i = ack;
        bus.eoi_i     = eoi;
        rst_n         = rn;
        exp_q.push_back(model_out());
        model_step(req, we, md, ack, eoi, rn);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic [26:0] req);
        cyc(req, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic chk(input string name, input logic [33:0] got, input logic [33:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %h required %h", name, got, want);
        end
    endtask

    function automatic logic [33:0] snap();
        return {bus.irq_o, bus.irq_id_o, bus.busy_o, bus.pending_o};
    endfunction

    // Monitor: compares every sampled cycle against the queued expectation
    initial begin
        exp_t e, g;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                g = {bus.irq_o, bus.irq_id_o, bus.busy_o, bus.pending_o};
                checks++;
                if (g !== e) begin
                    failures++;
                    $display("FAIL sb t=%0t: got irq=%0b id=%0d busy=%0b pend=%h required irq=%0b id=%0d busy=%0b pend=%h",
                             $time, g.irq, g.id, g.busy, g.pend, e.irq, e.id, e.busy, e.pend);
                end
            end
        end
    end

    initial begin
        logic [26:0] r, md;
        logic        we, ack, eoi, rn;

        bus.req_i = '0; bus.mask_we_i = 1'b0; bus.mask_d_i = '0;
        bus.irq_ack_i = 1'b0; bus.eoi_i = 1'b0; rst_n = 1'b0;
        @(posedge clk);
        #1;
        model_step('0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        chk("reset", snap(), {1'b0, 5'd31, 1'b0, 27'h0});

        // Scenario 1: single channel 12 end to end
        cyc('0, 1'b1, '0, 1'b0, 1'b0, 1'b1);
        idle(27'h1000);
        chk("t1_pending", snap(), {1'b0, 5'd31, 1'b0, 27'h1000});
        idle('0);
        chk("t1_assert", snap(), {1'b1, 5'd12, 1'b1, 27'h1000});
        cyc('0, 1'b0, '0, 1'b1, 1'b0, 1'b1);
        chk("t1_service", snap(), {1'b0, 5'd12, 1'b1, 27'h0});
        cyc('0, 1'b0, '0, 1'b0, 1'b1, 1'b1);
        chk("t1_eoi", snap(), {1'b0, 5'd31, 1'b0, 27'h0});

        // Scenario 2: simultaneous edges, lower index first
        idle((27'd1 << 20) | (27'd1 << 3));
        idle('0); idle('0);
        chk("t2_first", snap(), {1'b1, 5'd3, 1'b1, (27'd1 << 20) | (27'd1 << 3)});
        cyc('0, 1'b0, '0, 1'b1, 1'b0, 1'b1);
        idle('0);
        cyc('0, 1'b0, '0, 1'b0, 1'b1, 1'b1);
        idle('0);
        chk("t2_second", snap(), {1'b1, 5'd20, 1'b1, 27'd1 << 20});
        cyc('0, 1'b0, '0, 1'b1, 1'b1, 1'b1);
        cyc('0, 1'b0, '0, 1'b0, 1'b1, 1'b1);

        // Scenario 3: masked pending, released by unmask
        cyc('0, 1'b1, 27'd1 << 5, 1'b0, 1'b0, 1'b1);
        idle(27'd1 << 5);
        idle('0); idle('0);
        chk("t3_masked", snap(), {1'b0, 5'd31, 1'b0, 27'd1 << 5});
        cyc('0, 1'b1, '0, 1'b0, 1'b0, 1'b1);
        idle('0);
        chk("t3_unmask", snap(), {1'b1, 5'd5, 1'b1, 27'd1 << 5});
        cyc('0, 1'b0, '0, 1'b1, 1'b0, 1'b1);
        cyc('0, 1'b0, '0, 1'b0, 1'b1, 1'b1);

        // Scenario 4: withdraw on mask while offered
        idle(27'd1 << 7);
        idle('0); idle('0);
        cyc('0, 1'b1, 27'd1 << 7, 1'b0, 1'b0, 1'b1);
        idle('0);
        chk("t4_withdraw", snap(), {1'b0, 5'd31, 1'b0, 27'd1 << 7});
        cyc('0, 1'b1, '0, 1'b0, 1'b0, 1'b1);
        idle('0);
        chk("t4_represent", snap(), {1'b1, 5'd7, 1'b1, 27'd1 << 7});
        cyc('0, 1'b0, '0, 1'b1, 1'b0, 1'b1);
        cyc('0, 1'b0, '0, 1'b0, 1'b1, 1'b1);

        // Scenario 5: level-held request served once; edge colliding with ack
        idle(27'd1); idle(27'd1); idle(27'd1);
        cyc(27'd1, 1'b0, '0, 1'b1, 1'b0, 1'b1);
        cyc(27'd1, 1'b0, '0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) idle(27'd1);
        chk("t5_once", snap(), {1'b0, 5'd31, 1'b0, 27'h0});
        idle('0); idle(27'd1); idle('0); idle('0);
        cyc(27'd1, 1'b0, '0, 1'b1, 1'b0, 1'b1);
        chk("t5_collide", snap(), {1'b0, 5'd0, 1'b1, 27'h1});
        cyc(27'd1, 1'b0, '0, 1'b0, 1'b1, 1'b1);
        idle(27'd1);
        chk("t5_again", snap(), {1'b1, 5'd0, 1'b1, 27'h1});
        cyc('0, 1'b0, '0, 1'b1, 1'b0, 1'b1);

        // Scenario 6: reset during service
        cyc('0, 1'b0, '0, 1'b0, 1'b1, 1'b1);
        idle(27'h4000001);
        idle('0); idle('0);
        cyc('0, 1'b0, '0, 1'b1, 1'b0, 1'b1);
        idle(27'h1);
        idle('0);
        chk("t6_pre", snap(), {1'b0, 5'd0, 1'b1, 27'h4000001});
        cyc('0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        chk("t6_reset", snap(), {1'b0, 5'd31, 1'b0, 27'h0});

        // Random traffic
        r = '0;
        for (int k = 0; k < 4000; k++) begin
            r   = r ^ (27'($urandom) & 27'($urandom) & 27'($urandom) & 27'($urandom) & 27'($urandom));
            we  = ($urandom_range(0, 19) == 0);
            md  = 27'($urandom) & 27'($urandom);
            ack = ($urandom_range(0, 2) == 0);
            eoi = ($urandom_range(0, 2) == 0);
            rn  = ($urandom_range(0, 299) != 0);
            cyc(r, we, md, ack, eoi, rn);
        end

        repeat (2) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d left required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_irq_sched_ctrl
`default_nettype wire
